// File: rtl/spi_flash_responder.sv
// Quad-SPI flash responder (mode 0) serving reads from a byte-wide memory port.
// Define SPI_FLASH_RESPONDER_XIP_EN to enable 0xEB continuous-read (XIP) mode.
module spi_flash_responder #(
    parameter int          ADDR_W     = 24,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
    parameter int          FAST_DUMMY = 8,
    parameter int          QIO_DUMMY  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spiflash4x_clk,
    input  logic              spiflash4x_cs_n,
    input  logic [3:0]        spiflash4x_dq_i,
    output logic [3:0]        spiflash4x_dq_o,
    output logic [3:0]        spiflash4x_dq_oe,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              underrun
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR1, S_ADDR4, S_MODE,
        S_DUMMY, S_DATA, S_ID, S_STAT, S_IGNORE
    } state_t;

    state_t            state;
    logic [1:0]        sclk_q;
    logic              sclk_d;
    logic [1:0]        cs_q;
    logic [3:0]        dq_q1, dq_s;
    logic [7:0]        cmd, cnt, tx, rbuf;
    logic [2:0]        txcnt;
    logic              quad, buf_valid;
    logic [ADDR_W-1:0] addr_sh, a_next;
    logic [23:0]       id_sh;
    logic              rise, fall, cs_s, ack, avail;
    logic [7:0]        next_byte, cmd_next;
    logic [3:0]        slot, load_slot;
`ifdef SPI_FLASH_RESPONDER_XIP_EN
    logic [7:0]        mode, mode_next;
    logic              xip;
`endif

    assign cs_s = cs_q[1];
    assign rise = sclk_q[1] & ~sclk_d;
    assign fall = ~sclk_q[1] & sclk_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_q <= 2'b00;
            sclk_d <= 1'b0;
            cs_q   <= 2'b11;
            dq_q1  <= 4'h0;
            dq_s   <= 4'h0;
        end else begin
            sclk_q <= {sclk_q[0], spiflash4x_clk};
            sclk_d <= sclk_q[1];
            cs_q   <= {cs_q[0], spiflash4x_cs_n};
            dq_q1  <= spiflash4x_dq_i;
            dq_s   <= dq_q1;
        end
    end

    always_comb begin
        ack       = mem_req && mem_ack;
        avail     = buf_valid || ack;
        next_byte = 8'hFF;
        if (buf_valid)
            next_byte = rbuf;
        else if (ack)
            next_byte = mem_rdata;
        cmd_next = {cmd[6:0], dq_s[0]};
        if (state == S_ADDR4)
            a_next = (addr_sh << 4) | ADDR_W'(dq_s);
        else
            a_next = (addr_sh << 1) | ADDR_W'(dq_s[0]);
        slot      = quad ? tx[7:4] : {2'b00, tx[7], 1'b0};
        load_slot = quad ? next_byte[7:4] : {2'b00, next_byte[7], 1'b0};
`ifdef SPI_FLASH_RESPONDER_XIP_EN
        mode_next = (mode << 4) | 8'(dq_s);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            spiflash4x_dq_o  <= 4'h0;
            spiflash4x_dq_oe <= 4'h0;
            mem_req          <= 1'b0;
            mem_addr         <= '0;
            underrun         <= 1'b0;
            cmd              <= 8'h00;
            cnt              <= 8'h00;
            tx               <= 8'h00;
            rbuf             <= 8'h00;
            txcnt            <= 3'd0;
            quad             <= 1'b0;
            buf_valid        <= 1'b0;
            addr_sh          <= '0;
            id_sh            <= 24'h0;
`ifdef SPI_FLASH_RESPONDER_XIP_EN
            mode             <= 8'h00;
            xip              <= 1'b0;
`endif
        end else begin
            if (ack) begin
                rbuf      <= mem_rdata;
                buf_valid <= 1'b1;
                mem_req   <= 1'b0;
            end
            // CS_n high overrides everything, including a same-cycle SCLK edge
            if (cs_s) begin
                state            <= S_IDLE;
                spiflash4x_dq_o  <= 4'h0;
                spiflash4x_dq_oe <= 4'h0;
                cnt              <= 8'h00;
                txcnt            <= 3'd0;
                mem_req          <= 1'b0;
                buf_valid        <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
`ifdef SPI_FLASH_RESPONDER_XIP_EN
                        if (xip) begin
                            state <= S_ADDR4;
                            cmd   <= 8'hEB;
                            quad  <= 1'b1;
                            cnt   <= 8'(ADDR_W / 4 - 1);
                        end else begin
                            state <= S_CMD;
                            cnt   <= 8'd7;
                        end
`else
                        state <= S_CMD;
                        cnt   <= 8'd7;
`endif
                    end
                    S_CMD: if (rise) begin
                        cmd <= cmd_next;
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd0) begin
                            case (cmd_next)
                                8'h03, 8'h0B: begin
                                    state <= S_ADDR1;
                                    quad  <= 1'b0;
                                    cnt   <= 8'(ADDR_W - 1);
                                end
                                8'h6B: begin
                                    state <= S_ADDR1;
                                    quad  <= 1'b1;
                                    cnt   <= 8'(ADDR_W - 1);
                                end
                                8'hEB: begin
                                    state <= S_ADDR4;
                                    quad  <= 1'b1;
                                    cnt   <= 8'(ADDR_W / 4 - 1);
                                end
                                8'h9F: begin
                                    state <= S_ID;
                                    id_sh <= JEDEC_ID;
                                end
                                8'h05:   state <= S_STAT;
                                default: state <= S_IGNORE;
                            endcase
                        end
                    end
                    S_ADDR1, S_ADDR4: if (rise) begin
                        addr_sh <= a_next;
                        cnt     <= cnt - 8'd1;
                        if (cnt == 8'd0) begin
                            mem_addr  <= a_next;
                            mem_req   <= 1'b1;
                            buf_valid <= 1'b0;
                            txcnt     <= 3'd0;
                            if (cmd == 8'hEB) begin
                                state <= S_MODE;
                                cnt   <= 8'd1;
                            end else if (cmd == 8'h03) begin
                                state <= S_DATA;
                            end else begin
                                state <= S_DUMMY;
                                cnt   <= 8'(FAST_DUMMY - 1);
                            end
                        end
                    end
                    S_MODE: if (rise) begin
                        cnt <= cnt - 8'd1;
`ifdef SPI_FLASH_RESPONDER_XIP_EN
                        mode <= mode_next;
                        if (cnt == 8'd0)
                            xip <= (mode_next & 8'h30) == 8'h20;
`endif
                        if (cnt == 8'd0) begin
                            state <= S_DUMMY;
                            cnt   <= 8'(QIO_DUMMY - 1);
                        end
                    end
                    S_DUMMY: if (rise) begin
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd0)
                            state <= S_DATA;
                    end
                    S_DATA: if (fall) begin
                        spiflash4x_dq_oe <= quad ? 4'b1111 : 4'b0010;
                        if (txcnt == 3'd0) begin
                            spiflash4x_dq_o <= load_slot;
                            tx        <= quad ? {next_byte[3:0], 4'h0}
                                              : {next_byte[6:0], 1'b0};
                            txcnt     <= quad ? 3'd1 : 3'd7;
                            buf_valid <= 1'b0;
                            if (!avail)
                                underrun <= 1'b1;
                        end else begin
                            spiflash4x_dq_o <= slot;
                            tx    <= quad ? {tx[3:0], 4'h0} : {tx[6:0], 1'b0};
                            txcnt <= txcnt - 3'd1;
                            // last bit out: prefetch the next byte unless a fetch is still owed
                            if (txcnt == 3'd1 && !mem_req && !buf_valid) begin
                                mem_addr <= mem_addr + 1'b1;
                                mem_req  <= 1'b1;
                            end
                        end
                    end
                    S_ID: if (fall) begin
                        spiflash4x_dq_o  <= {2'b00, id_sh[23], 1'b0};
                        spiflash4x_dq_oe <= 4'b0010;
                        id_sh            <= {id_sh[22:0], id_sh[23]};
                    end
                    S_STAT: if (fall) begin
                        spiflash4x_dq_o  <= 4'h0;
                        spiflash4x_dq_oe <= 4'b0010;
                    end
                    S_IGNORE: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: SPI initiator, memory model and byte scoreboard.
module tb_spi_flash_responder;

    localparam int FAST_DUMMY = 8;
    localparam int QIO_DUMMY  = 4;
    localparam logic [23:0] JID = 24'hEF4016;

    logic        clk = 1'b0;
    logic        reset;
    logic        spiflash4x_clk, spiflash4x_cs_n;
    logic [3:0]  spiflash4x_dq_i;
    logic [3:0]  spiflash4x_dq_o, spiflash4x_dq_oe;
    logic        mem_req, mem_ack, underrun;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] b;
        bit         quad;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] req_log[$];
    bit          ack_off = 1'b0;
    int          lat_min = 1;
    int          lat_max = 3;
    logic [7:0]  key = 8'h00;

    always #5 clk = ~clk;

    spi_flash_responder dut (
        .clk(clk),
        .reset(reset),
        .spiflash4x_clk(spiflash4x_clk),
        .spiflash4x_cs_n(spiflash4x_cs_n),
        .spiflash4x_dq_i(spiflash4x_dq_i),
        .spiflash4x_dq_o(spiflash4x_dq_o),
        .spiflash4x_dq_oe(spiflash4x_dq_oe),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .underrun(underrun)
    );

    function automatic logic [7:0] mem_fn(input logic [23:0] a);
        return a[7:0] ^ key;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_cyc(input logic [3:0] d);
        spiflash4x_dq_i = d;
        tick(8);
        spiflash4x_clk = 1'b1;
        tick(8);
        spiflash4x_clk = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b);
        for (int i = 7; i >= 0; i--)
            spi_cyc({3'b000, b[i]});
    endtask

    task automatic end_cs();
        tick(4);
        spiflash4x_cs_n = 1'b1;
        tick(3);
        chk("oe_off_after_cs", 32'(spiflash4x_dq_oe), 32'h0);
        tick(4);
        chk("req_off_after_cs", 32'(mem_req), 32'h0);
    endtask

    // memory: ack each request after a random latency, log acked addresses
    initial begin
        int lat;
        bit ok;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_req && !ack_off) begin
                lat = $urandom_range(lat_max, lat_min);
                ok  = 1'b1;
                repeat (lat - 1) begin
                    @(negedge clk);
                    if (!mem_req) ok = 1'b0;
                end
                if (ok && mem_req && !ack_off) begin
                    req_log.push_back(mem_addr);
                    mem_rdata = mem_fn(mem_addr);
                    mem_ack   = 1'b1;
                    @(negedge clk);
                    mem_ack   = 1'b0;
                end
            end
        end
    end

    // monitor: assemble bytes where the initiator samples, compare to scoreboard
    logic [7:0] acc;
    int         nb;
    bit         mq;
    exp_t       e;
    always @(posedge spiflash4x_clk or posedge spiflash4x_cs_n) begin
        if (spiflash4x_cs_n) begin
            nb = 0;
        end else if (spiflash4x_dq_oe != 4'h0) begin
            mq = (spiflash4x_dq_oe == 4'b1111);
            if (!mq && spiflash4x_dq_oe != 4'b0010)
                chk("oe_pattern", 32'(spiflash4x_dq_oe), 32'h2);
            acc = mq ? {acc[3:0], spiflash4x_dq_o} : {acc[6:0], spiflash4x_dq_o[1]};
            nb += mq ? 4 : 1;
            if (nb >= 8) begin
                nb = 0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h expected none", acc);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_byte", 32'(acc), 32'(e.b));
                    chk("data_lanes", 32'(mq), 32'(e.quad));
                end
            end
        end
    end

    task automatic rd(input logic [7:0] cmd, input logic [23:0] a, input int n,
                      input logic [7:0] mode, input bit skip_cmd, input bit want_ff);
        bit q;
        q = (cmd == 8'h6B) || (cmd == 8'hEB);
        req_log.delete();
        for (int i = 0; i < n; i++)
            exp_q.push_back('{want_ff ? 8'hFF : mem_fn(24'(a + 24'(i))), q});
        spiflash4x_cs_n = 1'b0;
        tick(4);
        if (!skip_cmd) send1(cmd);
        if (cmd == 8'hEB) begin
            for (int k = 5; k >= 0; k--)
                spi_cyc(a[k*4 +: 4]);
            spi_cyc(mode[7:4]);
            spi_cyc(mode[3:0]);
            repeat (QIO_DUMMY) spi_cyc(4'h0);
        end else begin
            for (int k = 23; k >= 0; k--)
                spi_cyc({3'b000, a[k]});
            if (cmd != 8'h03)
                repeat (FAST_DUMMY) spi_cyc(4'h0);
        end
        repeat (n * (q ? 2 : 8)) spi_cyc(4'h0);
        end_cs();
        chk("bytes_drained", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        if (!want_ff) begin
            chk("req_count", 32'(req_log.size()), 32'(n + 1));
            for (int i = 0; i < req_log.size(); i++)
                chk("req_addr", 32'(req_log[i]), 32'(24'(a + 24'(i))));
        end
    endtask

    task automatic id_read(input logic [7:0] cmd, input int n);
        logic [23:0] jid;
        jid = JID;
        for (int i = 0; i < n; i++)
            exp_q.push_back('{cmd == 8'h9F ? jid[23 - 8 * (i % 3) -: 8] : 8'h00, 1'b0});
        spiflash4x_cs_n = 1'b0;
        tick(4);
        send1(cmd);
        repeat (n * 8) spi_cyc(4'h0);
        end_cs();
        chk("id_drained", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        chk("rst_dq_o", 32'(spiflash4x_dq_o), 32'h0);
        chk("rst_dq_oe", 32'(spiflash4x_dq_oe), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_underrun", 32'(underrun), 32'h0);
        reset = 1'b0;
        tick(2);
    endtask

    initial begin
        logic [3:0]  oe_or;
        logic [7:0]  c;
        logic [23:0] a;
        logic [7:0]  cmds[4];
        cmds = '{8'h03, 8'h0B, 8'h6B, 8'hEB};
        reset = 1'b1;
        spiflash4x_clk = 1'b0;
        spiflash4x_cs_n = 1'b1;
        spiflash4x_dq_i = 4'h0;
        tick(2);
        do_reset();

        id_read(8'h9F, 4);
        id_read(8'h05, 2);
        rd(8'h03, 24'h000010, 3, 8'h00, 1'b0, 1'b0);

        lat_min = 2;
        lat_max = 2;
        rd(8'hEB, 24'h000100, 2, 8'h00, 1'b0, 1'b0);
        chk("underrun_clear", 32'(underrun), 32'h0);
        lat_min = 1;
        lat_max = 3;
        rd(8'h03, 24'hFFFFFF, 2, 8'h00, 1'b0, 1'b0);

        for (int it = 0; it < 14; it++) begin
            key = 8'($urandom);
            c = cmds[$urandom_range(3, 0)];
            a = ($urandom_range(3, 0) == 0) ? 24'hFFFFFF - 24'($urandom_range(2, 0))
                                            : 24'($urandom);
            rd(c, a, $urandom_range(3, 1), 8'($urandom) & 8'hCF, 1'b0, 1'b0);
        end
        key = 8'h00;

        // abort mid-byte, then an unsupported command must stay silent
        spiflash4x_cs_n = 1'b0;
        tick(4);
        send1(8'h03);
        for (int k = 23; k >= 0; k--)
            spi_cyc({3'b000, 1'(24'h000040 >> k)});
        repeat (4) spi_cyc(4'h0);
        end_cs();
        tick(6);
        chk("abort_req", 32'(mem_req), 32'h0);
        oe_or = 4'h0;
        spiflash4x_cs_n = 1'b0;
        tick(4);
        send1(8'hAB);
        for (int i = 0; i < 16; i++) begin
            spi_cyc(4'h0);
            oe_or |= spiflash4x_dq_oe;
        end
        chk("ignore_oe", 32'(oe_or), 32'h0);
        chk("ignore_req", 32'(mem_req), 32'h0);
        end_cs();
        id_read(8'h9F, 4);

`ifdef SPI_FLASH_RESPONDER_XIP_EN
        rd(8'hEB, 24'h001000, 1, 8'hA0, 1'b0, 1'b0);
        rd(8'hEB, 24'h000020, 1, 8'hA0, 1'b1, 1'b0);
        rd(8'hEB, 24'h000030, 1, 8'hFF, 1'b1, 1'b0);
        id_read(8'h9F, 3);
`endif

        ack_off = 1'b1;
        rd(8'h03, 24'hFFFFFF, 2, 8'h00, 1'b0, 1'b1);
        ack_off = 1'b0;
        chk("underrun_set", 32'(underrun), 32'h1);
        id_read(8'h9F, 3);
        chk("underrun_sticky", 32'(underrun), 32'h1);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable quad-SPI flash target (responder). It answers the same spiflash4x bus that the SoC's SPI flash controller drives as initiator.
- Serves read commands from a byte-wide memory request port.
- Used in simulation and FPGA bring-up in place of an external W25Q-class flash.
- Oversamples the SPI pins on the system clock. SPI mode 0 only: sample on rising SCLK, drive on falling SCLK.

Parameters:
- ADDR_W, 24, byte address width on the SPI bus and the memory port.
- JEDEC_ID, 24'hEF4016, 3 bytes returned MSB-first for command 0x9F.
- FAST_DUMMY, 8, dummy SCLK cycles for 0x0B and 0x6B.
- QIO_DUMMY, 4, dummy SCLK cycles after the mode byte for 0xEB.

Ports:
- clk  input  1  system clock; must be at least 8x SCLK.
- reset  input  1  asynchronous, active-high.
- spiflash4x_clk  input  1  SCLK from the initiator.
- spiflash4x_cs_n  input  1  chip select, active-low.
- spiflash4x_dq_i  input  4  DQ pad inputs (dq[0]=DI, dq[1]=DO, dq[2]=WPn, dq[3]=HOLDn).
- spiflash4x_dq_o  output  4  DQ output values.
- spiflash4x_dq_oe  output  4  per-bit output enable.
- mem_req  output  1  byte fetch request; held high until mem_ack.
- mem_addr  output  ADDR_W  fetch address.
- mem_ack  input  1  single-cycle; mem_rdata is valid in the same cycle.
- mem_rdata  input  8  fetched byte.
- underrun  output  1  sticky; data was needed before mem_ack arrived.

Behaviour:
- Reset: dq_o=0, dq_oe=0, mem_req=0, mem_addr=0, underrun=0, state=IDLE. Synchronizers are cleared to sclk=0 and cs_n=1.
- Input sync: SCLK, CS_n and DQ_i each pass through 2 flops. Edges are detected on the synced SCLK.
- Output timing: dq_o and dq_oe update 3 clk after the falling pad edge. Rising-edge sampling lags by the same 3 clk.
- CS_n synced high, in any state: go to IDLE next clk, dq_oe=0, bit counters cleared, mem_req dropped. A pending ack is discarded. This is the only way out of IGNORE.
- Command, address and data are shifted MSB-first.
- IDLE -> CMD on synced CS_n falling.
- CMD: shift 8 bits on dq[0].
  - 0x03, 0x0B, 0x6B -> ADDR1 (1 bit per edge).
  - 0xEB -> ADDR4 (4 bits per edge).
  - 0x9F -> ID.
  - 0x05 -> STAT.
  - Any other value -> IGNORE (dq_oe stays 0).
- ADDR1/ADDR4: shift ADDR_W bits. On the completing edge, latch addr and assert mem_req with mem_addr=addr.
  - 0x03 -> DATA next.
  - 0x0B / 0x6B -> DUMMY, FAST_DUMMY cycles.
  - 0xEB -> MODE.
- MODE: 2 SCLK cycles sample 8 bits on dq[3:0], then DUMMY for QIO_DUMMY cycles.
- DATA:
  - Single-lane commands (0x03, 0x0B): dq[1] driven, oe=4'b0010.
  - Quad commands (0x6B, 0xEB): dq[3:0] driven, oe=4'b1111.
  - The first bit or nibble is driven on the falling edge that ends the last address/dummy cycle, from the byte latched on mem_ack.
  - When the last bit of a byte is loaded into the shifter: addr <= addr+1, wrapping modulo 2^ADDR_W (0xFFFFFF -> 0x000000), and mem_req is re-asserted for the next byte.
  - If a byte is needed and no ack has arrived: shift out 0xFF and set underrun.
- ID: drive JEDEC_ID on dq[1], 24 bits, then repeat from its MSB while CS_n stays low.
- STAT: drive 0x00 on dq[1], repeated.
- Simultaneous SCLK edge and CS_n rise in the same synced cycle: CS_n wins; the edge is ignored.
- mem_req is never asserted outside ADDR-complete and DATA.

Optional Feature:
- Macro SPI_FLASH_RESPONDER_XIP_EN.
- With the macro: in 0xEB, a mode byte with bits [5:4]=2'b10 sets the xip flag. The next CS_n falling then skips CMD and enters ADDR4 directly as 0xEB. Any other mode byte clears xip. reset clears xip.
- Without the macro: the mode byte is sampled and discarded, and every transaction starts in CMD.

Test Plan:
- JEDEC ID: CS low, 0x9F, 32 SCLK -> dq[1] returns EF 40 16 EF; dq_oe=4'b0010 during data only; oe=0 within 3 clk of CS_n rise.
- Read 0x03 at 0x000010, memory mem[a]=a[7:0]: 3 bytes -> 10 11 12 on dq[1]; mem_addr sequence 0x10, 0x11, 0x12, 0x13 (the last is the prefetch).
- Quad I/O 0xEB at 0x000100, mode 0x00, 4 dummy, mem ack 2 clk after req -> nibbles 0,0,0,1 for 0x00 then 0x01; oe=4'b1111; underrun=0.
- Wrap and underrun:
  - 0x03 at 0xFFFFFF, 2 bytes -> FF then mem[0x000000].
  - Same read with mem_ack held off -> 0xFF on the wire, underrun=1, sticky until reset.
- Abort: CS_n high in the middle of a DATA byte, then 0xAB and 16 clocks -> IDLE; mem_req=0; oe stays 0 through 0xAB; the next 0x9F works normally.
- SPI_FLASH_RESPONDER_XIP_EN: 0xEB with mode 0xA0, then a second CS with only address 0x000020 -> data mem[0x20]. A third transaction with mode 0xFF followed by a normal 0x9F -> ID returned.
